dcpu16_mbus_arb: RTL and testbench
==================================

Name: dcpu16_mbus_arb

Overview:
- Parametrised N-master to 1-slave arbiter on the simplified Wishbone bus (adr/stb/wre/dto/dti/ack).
- Lets the F-BUS, G-BUS and future DMA or peripheral masters share one memory port instead of using dedicated ports.
- Round-robin grant, registered slave-side outputs, registered per-master acks.
- Masters keep the existing stall rule: stall while `stb ~^ ack` is false.

Parameters:
- NM, 2: number of masters (>=1).
- AW, 16: address width.
- DW, 16: data width.
- TOW, 4: timeout counter width. Used only with DCPU16_MBUS_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- m_adr  in  NM*AW  master addresses; master i at bits [i*AW +: AW]
- m_dto  in  NM*DW  master write data; master i at bits [i*DW +: DW]
- m_stb  in  NM  master request strobes
- m_wre  in  NM  master write enables
- m_dti  out  DW  read data, shared by all masters; valid with m_ack
- m_ack  out  NM  one-hot, one-cycle acknowledge
- m_err  out  1  error flag, qualifies m_ack (timeout)
- s_adr  out  AW  slave address
- s_dto  out  DW  slave write data
- s_stb  out  1  slave strobe
- s_wre  out  1  slave write enable
- s_dti  in  DW  slave read data
- s_ack  in  1  slave acknowledge

Behaviour:
- Reset values:
  - s_adr=0, s_dto=0, s_stb=0, s_wre=0.
  - m_ack=0, m_dti=0, m_err=0.
  - state=IDLE, last-grant pointer=NM-1, so master 0 wins first.
- Master protocol:
  - A master asserts stb with adr/wre/dto stable and holds them until it sees its m_ack.
  - Withdrawing stb before ack is a protocol violation. Once granted, the transaction completes anyway.
  - If stb is still high in the cycle after ack, that is a new request.
- IDLE state:
  - If any m_stb is set, pick a winner round-robin, starting at (last+1) mod NM and wrapping.
  - Register the winner's adr/dto/wre onto s_*, set s_stb=1, update last, go to BUSY.
  - Latency: 1 cycle from request to s_stb.
- BUSY state:
  - s_* are held.
  - On s_ack: s_stb<=0, s_wre<=0, m_dti<=s_dti (for writes too), m_ack[grant]<=1, go to ACK.
  - s_ack while s_stb=0 is ignored.
- ACK state:
  - m_ack is high for exactly this one cycle.
  - No new grant is made in this cycle, because the acked master's stb is still visible.
  - Next state is IDLE; m_ack<=0.
- Timing:
  - Minimum transaction is 3 cycles plus slave wait states.
  - With all NM masters requesting continuously, each is served once every NM grants.
- Width rules:
  - Pointer width is max(1, clog2(NM)).
  - For NM=1, arbitration degenerates to pass-through with the same latency.
- Reset mid-transaction:
  - s_stb drops on the reset edge and any pending ack is discarded.
  - Masters restart their request after reset.
- m_dti holds its last value between acks.

Optional Feature:
- Macro: DCPU16_MBUS_TIMEOUT_EN.
- Enabled:
  - A TOW-bit counter clears on entry to BUSY and increments each BUSY cycle without s_ack.
  - When the counter reaches all-ones, set s_stb<=0 and go to ACK with m_ack[grant]=1, m_err=1, m_dti=0.
  - s_ack in the same cycle as the terminal count wins: normal completion, m_err=0.
- Disabled:
  - No counter; BUSY waits indefinitely.
  - m_err is tied 0.

Decomposition:
- Package dcpu16_mbus_pkg holds:
  - state encoding (IDLE=2'd0, BUSY=2'd1, ACK=2'd2);
  - the pointer-width function;
  - default widths.
- Sub-module dcpu16_rr_pick: combinational round-robin picker.
  - Inputs: req[NM], last pointer.
  - Outputs: grant index, any.
  - Instantiated once.

Test Plan:
- Single read, NM=2: m0 stb, adr=0x1234; slave acks 2 cycles after s_stb with s_dti=0xBEEF.
  - Expect s_stb one cycle after m_stb, s_adr=0x1234, s_wre=0.
  - Expect m_ack=2'b01 one cycle after s_ack, m_dti=0xBEEF, m_err=0.
- Simultaneous requests: m0 adr=0x0010 and m1 adr=0x0020 both stb at cycle 0; slave acks immediately.
  - Expect m0 served first (0x0010), then m1 (0x0020).
  - Neither is double-acked.
- Fairness: m0 and m1 request continuously for 6 transactions.
  - Expect grant order 0,1,0,1,0,1.
  - m_ack is never high in consecutive cycles.
- Write: m1 wre=1, adr=0x8000, dto=0x5A5A.
  - Expect s_wre=1, s_dto=0x5A5A, s_adr=0x8000 held until s_ack.
  - Expect m_ack=2'b10.
- Timeout (macro on, TOW=4): slave never acks.
  - Expect s_stb to drop after 15 BUSY cycles.
  - Expect m_ack pulse with m_err=1, m_dti=0, then arbiter returns to IDLE.
- Reset mid-BUSY: assert rst while s_stb=1, then drive s_ack during reset.
  - Expect s_stb=0 on the next edge, no m_ack, pointer=NM-1.
  - After reset, master 0 wins first.

Source files
------------

// File: rtl/dcpu16_mbus_pkg.sv
// Shared definitions for the dcpu16 memory-bus arbiter: state encoding,
// pointer-width helper and default bus widths.
package dcpu16_mbus_pkg;

    localparam int DEF_NM  = 2;
    localparam int DEF_AW  = 16;
    localparam int DEF_DW  = 16;
    localparam int DEF_TOW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Width of a master index; never zero so NM=1 still has a 1-bit pointer.
    function automatic int ptr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dcpu16_rr_pick.sv
// Combinational round-robin picker: searches req starting at (last+1) mod NM,
// wrapping, and returns the first requester found.
module dcpu16_rr_pick
    import dcpu16_mbus_pkg::*;
#(
    parameter int NM = DEF_NM,
    parameter int PW = ptr_w(NM)
) (
    input  logic [NM-1:0] req,
    input  logic [PW-1:0] last,
    output logic [PW-1:0] grant,
    output logic          any
);

    // Walk from farthest to nearest so the nearest requester after last wins.
    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        any   = 1'b0;
        for (int k = NM; k >= 1; k--) begin
            idx = (int'(last) + k) % NM;
            if (req[idx]) begin
                grant = idx[PW-1:0];
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcpu16_mbus_arb.sv
// N-master to 1-slave round-robin arbiter for the simplified Wishbone bus.
// Optional slave timeout enabled by defining DCPU16_MBUS_TIMEOUT_EN.
module dcpu16_mbus_arb
    import dcpu16_mbus_pkg::*;
#(
    parameter int NM  = DEF_NM,
    parameter int AW  = DEF_AW,
    parameter int DW  = DEF_DW,
    parameter int TOW = DEF_TOW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NM*AW-1:0] m_adr,
    input  logic [NM*DW-1:0] m_dto,
    input  logic [NM-1:0]  m_stb,
    input  logic [NM-1:0]  m_wre,
    output logic [DW-1:0]  m_dti,
    output logic [NM-1:0]  m_ack,
    output logic           m_err,
    output logic [AW-1:0]  s_adr,
    output logic [DW-1:0]  s_dto,
    output logic           s_stb,
    output logic           s_wre,
    input  logic [DW-1:0]  s_dti,
    input  logic           s_ack
);

    localparam int PW = ptr_w(NM);

    state_t        state, state_nx;
    logic [PW-1:0] last;
    logic [PW-1:0] pick;
    logic          any;
    logic          tmo;

    dcpu16_rr_pick #(.NM(NM), .PW(PW)) u_pick (
        .req   (m_stb),
        .last  (last),
        .grant (pick),
        .any   (any)
    );

`ifdef DCPU16_MBUS_TIMEOUT_EN
    // Counter value one short of all-ones: the edge that would make it all-ones ends BUSY.
    localparam logic [TOW-1:0] CNT_LAST = ~TOW'(1);
    logic [TOW-1:0] cnt;

    // Count BUSY cycles without a slave ack; held at zero outside BUSY.
    always_ff @(posedge clk) begin
        if (rst || state != BUSY)
            cnt <= '0;
        else if (!s_ack)
            cnt <= cnt + 1'b1;
    end

    assign tmo = (state == BUSY) && !s_ack && (cnt == CNT_LAST);
`else
    logic unused_tow;
    assign unused_tow = ^TOW;
    assign tmo        = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next state: grant from IDLE, finish BUSY on ack or timeout, one ACK cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any) state_nx = BUSY;
            BUSY:    if (s_ack || tmo) state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Registered slave-side drive, grant pointer and master acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_adr <= '0;
            s_dto <= '0;
            s_stb <= 1'b0;
            s_wre <= 1'b0;
            m_ack <= '0;
            m_dti <= '0;
            m_err <= 1'b0;
            last  <= PW'(NM - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        s_adr <= m_adr[pick*AW +: AW];
                        s_dto <= m_dto[pick*DW +: DW];
                        s_wre <= m_wre[pick];
                        s_stb <= 1'b1;
                        last  <= pick;
                    end
                end
                BUSY: begin
                    // A real ack beats a timeout landing in the same cycle.
                    if (s_ack) begin
                        s_stb       <= 1'b0;
                        s_wre       <= 1'b0;
                        m_dti       <= s_dti;
                        m_ack[last] <= 1'b1;
                        m_err       <= 1'b0;
                    end else if (tmo) begin
                        s_stb       <= 1'b0;
                        s_wre       <= 1'b0;
                        m_dti       <= '0;
                        m_ack[last] <= 1'b1;
                        m_err       <= 1'b1;
                    end
                end
                ACK: begin
                    m_ack <= '0;
                    m_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcpu16_mbus_arb.sv
// Randomized scoreboard bench for dcpu16_mbus_arb (NM=2). Grants are predicted
// from the round-robin rule over the requests the bench itself drives; each
// slave response pushes the expected master reply, popped by a monitor.
module tb_dcpu16_mbus_arb;

    localparam int NM  = 2;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int TOW = 4;
`ifdef DCPU16_MBUS_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NM*AW-1:0] m_adr = '0;
    logic [NM*DW-1:0] m_dto = '0;
    logic [NM-1:0]    m_stb = '0;
    logic [NM-1:0]    m_wre = '0;
    logic [DW-1:0]    m_dti;
    logic [NM-1:0]    m_ack;
    logic             m_err;
    logic [AW-1:0]    s_adr;
    logic [DW-1:0]    s_dto;
    logic             s_stb;
    logic             s_wre;
    logic [DW-1:0]    s_dti = '0;
    logic             s_ack = 1'b0;

    dcpu16_mbus_arb #(.NM(NM), .AW(AW), .DW(DW), .TOW(TOW)) dut (
        .clk(clk), .rst(rst),
        .m_adr(m_adr), .m_dto(m_dto), .m_stb(m_stb), .m_wre(m_wre),
        .m_dti(m_dti), .m_ack(m_ack), .m_err(m_err),
        .s_adr(s_adr), .s_dto(s_dto), .s_stb(s_stb), .s_wre(s_wre),
        .s_dti(s_dti), .s_ack(s_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NM-1:0] ack;
        logic [DW-1:0] dti;
        logic          err;
    } exp_t;

    exp_t          q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_done   = 0;
    logic [AW-1:0] r_adr[NM];
    logic [DW-1:0] r_dto[NM];
    logic          r_wre[NM];
    bit            pend[NM];
    int            last_g = NM - 1;
    int            cur_g  = 0;
    int            busy_n = 0;
    int            wait_n = 0;
    bit            prev_sstb = 1'b0;
    bit            hold_slave = 1'b0;
    bit            got;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NM-1:0] oh(input int i);
        logic [NM-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic drive();
        for (int i = 0; i < NM; i++) begin
            m_adr[i*AW +: AW] = r_adr[i];
            m_dto[i*DW +: DW] = r_dto[i];
            m_wre[i]          = r_wre[i];
            m_stb[i]          = pend[i];
        end
    endtask

    task automatic new_req(input int i);
        r_adr[i] = AW'($urandom);
        r_dto[i] = DW'($urandom);
        r_wre[i] = 1'($urandom_range(0, 1));
        pend[i]  = 1'b1;
    endtask

    function automatic int pick_wait();
        if (TMO && $urandom_range(0, 15) == 0)
            return $urandom_range(13, 20);
        return $urandom_range(0, 3);
    endfunction

    // One bus cycle: predict/verify grants, play the slave, then the masters.
    task automatic step(input int req_pct);
        int w;
        @(negedge clk);
        if (s_stb && !prev_sstb) begin
            w = -1;
            for (int k = 1; k <= NM; k++) begin
                if (m_stb[(last_g + k) % NM]) begin
                    w = (last_g + k) % NM;
                    break;
                end
            end
            check("grant_with_request", 64'(w >= 0), 64'd1);
            if (w < 0) w = 0;
            check("grant_wre", 64'(s_wre), 64'(r_wre[w]));
            check("grant_dto", 64'(s_dto), 64'(r_dto[w]));
            last_g = w;
            cur_g  = w;
            busy_n = 0;
            wait_n = pick_wait();
        end
        if (s_stb)
            check("busy_adr", 64'(s_adr), 64'(r_adr[cur_g]));
        prev_sstb = s_stb;
        s_ack = 1'b0;
        if (s_stb) begin
            busy_n++;
            if (!hold_slave && busy_n == wait_n + 1) begin
                s_ack = 1'b1;
                s_dti = DW'($urandom);
                q.push_back('{ack: oh(cur_g), dti: s_dti, err: 1'b0});
            end else if (TMO && !hold_slave && busy_n == (1 << TOW) - 1) begin
                q.push_back('{ack: oh(cur_g), dti: '0, err: 1'b1});
            end
        end else if ($urandom_range(0, 7) == 0) begin
            s_ack = 1'b1;
            s_dti = DW'($urandom);
        end
        for (int i = 0; i < NM; i++) begin
            if (m_ack[i]) begin
                pend[i] = 1'b0;
                if (int'($urandom_range(0, 99)) < req_pct) new_req(i);
            end else if (!pend[i] && int'($urandom_range(0, 99)) < req_pct) begin
                new_req(i);
            end
        end
        drive();
    endtask

    function automatic bit quiet();
        bit b;
        b = !s_stb && (m_ack == '0) && (q.size() == 0);
        for (int i = 0; i < NM; i++) if (pend[i]) b = 1'b0;
        return b;
    endfunction

    task automatic drain();
        for (int c = 0; c < 400 && !quiet(); c++) step(0);
        check("drain_quiet", 64'(quiet()), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < NM; i++) begin
            r_adr[i] = '0; r_dto[i] = '0; r_wre[i] = 1'b0; pend[i] = 1'b0;
        end
        fork
            begin : monitor
                exp_t          e;
                bit            prev_ack;
                logic [DW-1:0] last_dti;
                prev_ack = 1'b0;
                last_dti = '0;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        prev_ack = 1'b0;
                        last_dti = '0;
                    end else if (m_ack != '0) begin
                        check("ack_not_back_to_back", 64'(prev_ack), 64'd0);
                        if (q.size() == 0) begin
                            check("ack_expected", 64'(m_ack), 64'd0);
                        end else begin
                            e = q.pop_front();
                            check("ack_onehot", 64'(m_ack), 64'(e.ack));
                            check("ack_dti", 64'(m_dti), 64'(e.dti));
                            check("ack_err", 64'(m_err), 64'(e.err));
                        end
                        last_dti = m_dti;
                        prev_ack = 1'b1;
                        n_done++;
                    end else begin
                        check("dti_hold", 64'(m_dti), 64'(last_dti));
                        check("err_idle", 64'(m_err), 64'd0);
                        prev_ack = 1'b0;
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("rst_s_adr", 64'(s_adr), 64'd0);
        check("rst_s_dto", 64'(s_dto), 64'd0);
        check("rst_s_stb", 64'(s_stb), 64'd0);
        check("rst_s_wre", 64'(s_wre), 64'd0);
        check("rst_m_ack", 64'(m_ack), 64'd0);
        check("rst_m_dti", 64'(m_dti), 64'd0);
        check("rst_m_err", 64'(m_err), 64'd0);
        rst = 1'b0;

        for (int c = 0; c < 1500; c++) step(30);
        for (int c = 0; c < 500; c++) step(100);
        drain();

        // Reset while master 0 is in BUSY; afterwards master 0 must win again.
        hold_slave = 1'b1;
        new_req(0);
        drive();
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            step(0);
            got = s_stb;
        end
        check("rst_setup_busy", 64'(got), 64'd1);
        rst   = 1'b1;
        s_ack = 1'b1;
        s_dti = DW'($urandom);
        @(negedge clk);
        check("rst_mid_s_stb", 64'(s_stb), 64'd0);
        check("rst_mid_m_ack", 64'(m_ack), 64'd0);
        @(negedge clk);
        check("rst_mid_m_ack2", 64'(m_ack), 64'd0);
        rst        = 1'b0;
        s_ack      = 1'b0;
        q.delete();
        last_g     = NM - 1;
        prev_sstb  = 1'b0;
        hold_slave = 1'b0;
        for (int i = 0; i < NM; i++) new_req(i);
        drive();
        drain();

        check("transactions_completed", 64'(n_done > 300), 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
